q_add: RTL and testbench



---
 rtl/q_pkg.sv | 10 +
 rtl/q_add_core.sv | 47 ++++
 rtl/q_add.sv | 45 ++++
 tb/tb_q_add.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
// Shared constants for the sign-magnitude fixed-point datapath.
// Default word layout: sign in the MSB, magnitude below it.
package q_pkg;
  localparam int unsigned N_DEF    = 32;
  localparam int unsigned Q_DEF    = 19;
  localparam int unsigned SIGN_BIT = N_DEF - 1;
  localparam int unsigned MAG_MSB  = N_DEF - 2;
  localparam logic [N_DEF-1:0] ZERO    = '0;
  localparam logic [N_DEF-2:0] MAG_SAT = '1;
endpackage

// File: rtl/q_add_core.sv
// Combinational sign-magnitude adder with saturation on magnitude overflow.
// Zero results are always returned as +0.
module q_add_core
  import q_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);
  localparam int unsigned SB = N - 1;

  logic         sa, sb;
  logic [N-2:0] ma, mb;
  logic [N-1:0] full;

  assign sa = a[SB];
  assign sb = b[SB];
  assign ma = a[N-2:0];
  assign mb = b[N-2:0];

  always_comb begin
    sum  = '0;
    ovf  = 1'b0;
    full = {1'b0, ma} + {1'b0, mb};
    if (sa == sb) begin
      if (full[SB]) begin
        sum = {sa, {(N-1){1'b1}}};
        ovf = 1'b1;
      end else begin
        sum = {sa, full[N-2:0]};
      end
    end else if (ma > mb) begin
      sum = {sa, ma - mb};
    end else if (mb > ma) begin
      sum = {sb, mb - ma};
    end else begin
      sum = '0;
    end
    // Covers -0 + -0 as well as exact cancellation.
    if (sum[N-2:0] == '0) begin
      sum[SB] = 1'b0;
    end
  end
endmodule

// File: rtl/q_add.sv
// Registered sign-magnitude fixed-point adder, one-cycle latency.
// Q only affects interpretation; the add logic is format-agnostic.
module q_add
  import q_pkg::*;
#(
  parameter int unsigned Q = Q_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] c,
  output logic         ovf
);
  if (Q > N - 1) begin : g_bad_q
    $error("q_add: Q exceeds magnitude width");
  end

  logic [N-1:0] sum;
  logic         sum_ovf;

  q_add_core #(.N(N)) u_core (
    .a   (a),
    .b   (b),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c   <= sum;
        ovf <= sum_ovf;
      end
    end
  end
endmodule

// File: tb/tb_q_add.sv
// Directed and random self-checking bench for q_add against a signed-integer model.
module tb_q_add;
  import q_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [N_DEF-1:0] a = '0;
  logic [N_DEF-1:0] b = '0;
  logic             out_valid;
  logic [N_DEF-1:0] c;
  logic             ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  q_add #(.Q(Q_DEF), .N(N_DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, c} computed via ordinary signed arithmetic.
  function automatic logic [N_DEF:0] model(input logic [N_DEF-1:0] x, input logic [N_DEF-1:0] y);
    longint vx, vy, s, m;
    logic [N_DEF-1:0] r;
    vx = longint'(x[MAG_MSB:0]);
    vy = longint'(y[MAG_MSB:0]);
    if (x[SIGN_BIT]) vx = -vx;
    if (y[SIGN_BIT]) vy = -vy;
    s = vx + vy;
    m = (s < 0) ? -s : s;
    if (m > longint'(MAG_SAT)) return {1'b1, (s < 0), MAG_SAT};
    if (m == 0) return {1'b0, ZERO};
    r = {(s < 0), m[MAG_MSB:0]};
    return {1'b0, r};
  endfunction

  task automatic step(input logic v, input logic [N_DEF-1:0] x, input logic [N_DEF-1:0] y);
    in_valid = v;
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [N_DEF-1:0] x, input logic [N_DEF-1:0] y,
                     input logic [N_DEF-1:0] ec, input logic eo);
    step(1'b1, x, y);
    chk({tag, ".c"}, 64'(c), 64'(ec));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    chk({tag, ".vld"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    logic [N_DEF-1:0] exp_c;
    logic             exp_o;
    logic [N_DEF:0]   mr;
    logic             v;
    logic [N_DEF-1:0] x, y;

    rst = 1'b1;
    step(1'b1, 32'd7, 32'd9);
    step(1'b0, '0, '0);
    chk("reset.c", 64'(c), 64'd0);
    chk("reset.ovf", 64'(ovf), 64'd0);
    chk("reset.vld", 64'(out_valid), 64'd0);
    rst = 1'b0;

    vec("basic",    32'd123,      32'd0,        32'd123,      1'b0);
    vec("p5m3",     32'd5,        32'h80000003, 32'h00000002, 1'b0);
    vec("m5p3",     32'h80000005, 32'd3,        32'h80000002, 1'b0);
    vec("m5m3",     32'h80000005, 32'h80000003, 32'h80000008, 1'b0);
    vec("cancel",   32'd3,        32'h80000003, 32'h00000000, 1'b0);
    vec("negzero",  32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    vec("negzero2", 32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
    vec("ovf_pos",  32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1);
    vec("ovf_neg",  32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFF, 1'b1);
    vec("max_nofl", 32'h7FFFFFFE, 32'h00000001, 32'h7FFFFFFF, 1'b0);
    vec("q19_add",  32'h00080000, 32'h00040000, 32'h000C0000, 1'b0);
    vec("q19_sub",  32'h00080000, 32'h800C0000, 32'h80040000, 1'b0);

    // Idle cycle: outputs hold, valid drops.
    step(1'b0, 32'd1, 32'd1);
    chk("hold.c", 64'(c), 64'h80040000);
    chk("hold.ovf", 64'(ovf), 64'd0);
    chk("hold.vld", 64'(out_valid), 64'd0);

    exp_c = 32'h80040000;
    exp_o = 1'b0;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      x = $urandom;
      y = $urandom;
      if (($urandom_range(0, 3)) == 0) x[30:28] = 3'b111;
      if (($urandom_range(0, 3)) == 0) y[30:28] = 3'b111;
      if (($urandom_range(0, 7)) == 0) y = x ^ 32'h80000000;
      step(v, x, y);
      if (v) begin
        mr = model(x, y);
        exp_c = mr[N_DEF-1:0];
        exp_o = mr[N_DEF];
      end
      chk("rand.c", 64'(c), 64'(exp_c));
      chk("rand.ovf", 64'(ovf), 64'(exp_o));
      chk("rand.vld", 64'(out_valid), 64'(v));
    end

    // Reset mid-stream: transaction presented with rst is dropped.
    vec("pre_rst", 32'h7FFFFFFF, 32'd5, 32'h7FFFFFFF, 1'b1);
    rst = 1'b1;
    step(1'b1, 32'd40, 32'd2);
    chk("midrst.c", 64'(c), 64'd0);
    chk("midrst.ovf", 64'(ovf), 64'd0);
    chk("midrst.vld", 64'(out_valid), 64'd0);
    rst = 1'b0;
    step(1'b0, 32'd40, 32'd2);
    chk("postrst.c", 64'(c), 64'd0);
    chk("postrst.vld", 64'(out_valid), 64'd0);
    vec("first_after", 32'd10, 32'd20, 32'd30, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
